inv_round_addkey_mix: RTL and testbench

//  Sequential decryption-round back end: XORs a 128-bit state with its round key (AddRoundKey), then applies

---
 rtl/inv_round_addkey_mix.sv | 136 +++++++++++++
 tb/tb_inv_round_addkey_mix.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_addkey_mix.sv
// Decryption round back end: AddRoundKey, then column-serial InvMixColumns (COLS_PER_CYCLE lanes).
// Latency: 1 edge when skip_mix is set, 1+4/COLS_PER_CYCLE edges otherwise; the result is held in DONE.
// Backpressure: result held stable without limit while out_ready=0; new block accepted on the same edge the result leaves.
module inv_round_addkey_mix #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

    fsm_t         state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  col_q [4];
    logic [31:0]  mix_col [COLS_PER_CYCLE];
    logic [127:0] mixed_blk;
    logic [1:0]   lane_idx;
    logic [2:0]   cnt_sum;
    logic         accept;

    // GF(2^8) multiply by x, reduction polynomial 0x11B
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Single-column InvMixColumns; byte 0 of the column sits in the MSBs
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int j = 0; j < 4; j++) begin
            a[j]  = c[31-8*j -: 8];
            x2    = xt(a[j]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    genvar gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            assign col_q[gc] = blk_q[127-32*gc -: 32];
        end
        // One transform lane per column handled this cycle, starting at cnt_q
        for (gc = 0; gc < COLS_PER_CYCLE; gc++) begin : g_lane
            assign mix_col[gc] = inv_mix_col(col_q[cnt_q + 2'(gc)]);
        end
    endgenerate

    assign cnt_sum   = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);
    assign state_out = blk_q;

    // Merge the freshly transformed columns back into the block
    always_comb begin
        mixed_blk = blk_q;
        lane_idx  = cnt_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            lane_idx = cnt_q + 2'(i);
            mixed_blk[127-32*int'(lane_idx) -: 32] = mix_col[i];
        end
    end

    // Next-state, datapath next value and handshake outputs
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            MIX:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        accept = in_valid & in_ready;

        case (state_q)
            MIX: begin
                blk_d = mixed_blk;
                cnt_d = cnt_sum[1:0];
                if (cnt_sum == 3'd4) state_d = DONE;
            end
            DONE: if (out_ready && !in_valid) state_d = IDLE;
            default: ;
        endcase

        // New block loads from IDLE or as a same-edge handoff out of DONE
        if (accept) begin
            blk_d   = state_in ^ round_key;
            cnt_d   = 2'd0;
            state_d = skip_mix ? DONE : MIX;
        end
    end

    // State registers with synchronous reset; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inv_round_addkey_mix.sv
// Testbench for inv_round_addkey_mix: directed vectors plus random blocks against a GF(2^8) matrix model.
// Two instances (1 and 4 columns per cycle) share the stimulus; use4 selects which one is checked.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_inv_round_addkey_mix;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_ready;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] state_out1;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] state_out4;
    logic         use4;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;

    int n_assert = 0;
    int n_fail   = 0;

    inv_round_addkey_mix dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
        .out_valid(out_valid1), .out_ready(out_ready), .state_out(state_out1), .busy(busy1)
    );

    inv_round_addkey_mix #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
        .out_valid(out_valid4), .out_ready(out_ready), .state_out(state_out4), .busy(busy4)
    );

    assign in_ready  = use4 ? in_ready4  : in_ready1;
    assign out_valid = use4 ? out_valid4 : out_valid1;
    assign busy      = use4 ? busy4      : busy1;
    assign state_out = use4 ? state_out4 : state_out1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic sk);
        logic [127:0] t = s ^ k;
        logic [127:0] r = '0;
        logic [7:0] row0 [4];
        logic [7:0] a [4];
        logic [7:0] b;
        row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        if (sk) return t;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = t[127-32*c-8*j -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(row0[(j - rr + 4) % 4], a[j]);
                r[127-32*c-8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges from the accept edge until out_valid rises, bounded
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Present one block from an idle DUT, check latency and result, then drain it
    task automatic send(input string tag, input logic [127:0] s, input logic [127:0] k,
                        input logic sk, input int exp_lat);
        int lat;
        state_in = s; round_key = k; skip_mix = sk; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        skip_mix = ~sk;
        wait_out(lat);
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_state_out"}, state_out, model(s, k, sk));
        step();
        chk({tag, "_drained"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] s, k, s2, k2, s3, k3;
        logic [127:0] t1_in, t1_out;
        int lat;

        t1_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        t1_out = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        rst = 1'b1; in_valid = 1'b0; state_in = '0; round_key = '0;
        skip_mix = 1'b0; out_ready = 1'b1; use4 = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_state_out", state_out, 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));

        // Known vector, mixing, plus the model's own agreement with the constant
        chk("model_known_vector", model(t1_in, 128'(0), 1'b0), t1_out);
        send("t1_mix", t1_in, 128'(0), 1'b0, 5);

        // Bypass: AddRoundKey only
        chk("model_bypass_vector",
            model(128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1),
            128'h00102030_40506070_8090a0b0_c0d0e0f0);
        send("t2_skip", 128'h00112233_44556677_8899aabb_ccddeeff,
             128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, 1);

        // Key equals state -> zero result
        s = {$urandom, $urandom, $urandom, $urandom};
        send("t3_zero", s, s, 1'b0, 5);

        // Random blocks, random bypass
        for (int i = 0; i < 8; i++) begin
            logic sk;
            s  = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            sk = 1'($urandom_range(0, 1));
            send("rand", s, k, sk, sk ? 1 : 5);
        end

        // Backpressure, then handoff into a second block
        out_ready = 1'b0;
        state_in = t1_in; round_key = '0; skip_mix = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_latency", 128'(lat), 128'(5));
        s2 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        state_in = s2; round_key = k2; skip_mix = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_state_out", state_out, t1_out);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("handoff_single_transfer", 128'(out_valid), 128'(0));
        chk("handoff_busy", 128'(busy), 128'(1));
        wait_out(lat);
        chk("handoff_latency", 128'(lat), 128'(5));
        chk("handoff_state_out", state_out, model(s2, k2, 1'b0));

        // Back-to-back with out_ready high: third block taken on the output edge
        s3 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        state_in = s3; round_key = k3; skip_mix = 1'b0; in_valid = 1'b1;
        chk("b2b_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("b2b_no_idle_busy", 128'(busy), 128'(1));
        chk("b2b_out_valid_low", 128'(out_valid), 128'(0));
        wait_out(lat);
        chk("b2b_latency", 128'(lat), 128'(5));
        chk("b2b_state_out", state_out, model(s3, k3, 1'b0));
        step();

        // Reset during the second MIX cycle
        s = {$urandom, $urandom, $urandom, $urandom};
        state_in = s; round_key = '0; skip_mix = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rst_mid_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_state_out", state_out, 128'(0));
        chk("rst_mid_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_stale_output", 128'(out_valid), 128'(0));
            step();
        end
        send("rst_fresh", t1_in, 128'(0), 1'b0, 5);

        // Four lanes per cycle
        use4 = 1'b1;
        #1;
        send("c4_t1", t1_in, 128'(0), 1'b0, 2);
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send("c4_rand", s, k, 1'b0, 2);
        send("c4_skip", s, k, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
